// File: rtl/mod_tick_gen_pkg.sv
// Shared constants for the multi-channel tick generator: table geometry, the
// production and bench divisor tables, and the per-cycle channel action encoding.
package mod_tick_gen_pkg;

  localparam int MTG_CNT_W   = 29;
  localparam int MTG_LVL_W   = 4;
  localparam int MTG_NUM_LVL = 2 ** MTG_LVL_W;

  // Half-period-1 at 100 MHz, entry[15] first: 16,14,12,10,9..4,3,2.5,2,1.5,1,0.5 Hz
  localparam logic [MTG_NUM_LVL*MTG_CNT_W-1:0] MTG_DEF_TABLE = {
    29'd3124999,  29'd3571428,  29'd4166666,  29'd4999999,
    29'd5555555,  29'd6249999,  29'd7142856,  29'd8333332,
    29'd9999999,  29'd12499999, 29'd16666666, 29'd19999999,
    29'd24999999, 29'd33333332, 29'd49999999, 29'd99999999
  };

  // Short divisors for simulation: lvl0=3, lvl1=1, lvl2=0, all others 5
  localparam logic [MTG_NUM_LVL*MTG_CNT_W-1:0] MTG_TB_TABLE = {
    {13{29'd5}}, 29'd0, 29'd1, 29'd3
  };

  typedef enum logic [1:0] {
    ACT_COUNT   = 2'd0,
    ACT_TOGGLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_RESTART = 2'd3
  } ch_act_e;

endpackage

// File: rtl/mod_tick_ch.sv
// One divider channel: input level register, half-period counter, square output,
// tick/ack pulses and the boundary-aligned (or legacy restart) divisor switch.
module mod_tick_ch
  import mod_tick_gen_pkg::*;
#(
  parameter int             CNT_W   = MTG_CNT_W,
  parameter int             LVL_W   = MTG_LVL_W,
  parameter bit             SYNC_SW = 1'b1,
  parameter logic [CNT_W-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LVL_W-1:0] lvl_i,
  input  logic             restart_i,
  input  logic             pause_i,
  input  logic [CNT_W-1:0] pend_div_i,
  output logic [LVL_W-1:0] lvl_q_o,
  output logic             clk_o,
  output logic             tick_o,
  output logic             ack_o,
  output logic [LVL_W-1:0] cur_lvl_o
);

  logic [LVL_W-1:0] lvl_q;
  logic [LVL_W-1:0] cur_lvl_q, cur_lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             sq_q, sq_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             lvl_diff;
  ch_act_e          act;

  assign lvl_diff = (lvl_q != cur_lvl_q);

  // Restart beats pause beats counting; legacy mode treats any level change as restart.
  always_comb begin
    act = ACT_COUNT;
    if (restart_i || (!SYNC_SW && lvl_diff)) act = ACT_RESTART;
    else if (pause_i)                         act = ACT_HOLD;
    else if (cnt_q == div_q)                  act = ACT_TOGGLE;
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold/idle default first, so no path infers a latch.
    cnt_d     = cnt_q;
    div_d     = div_q;
    cur_lvl_d = cur_lvl_q;
    sq_d      = sq_q;
    tick_d    = 1'b0;
    ack_d     = 1'b0;
    case (act)
      ACT_RESTART: begin
        cnt_d     = '0;
        sq_d      = 1'b0;
        div_d     = pend_div_i;
        cur_lvl_d = lvl_q;
        ack_d     = lvl_diff;
      end
      ACT_HOLD: begin
      end
      ACT_TOGGLE: begin
        cnt_d  = '0;
        sq_d   = ~sq_q;
        tick_d = 1'b1;
        if (SYNC_SW && lvl_diff) begin
          div_d     = pend_div_i;
          cur_lvl_d = lvl_q;
          ack_d     = 1'b1;
        end
      end
      ACT_COUNT: begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    endcase
  end

  // NOTE: reset is synchronous (sampled on the clock edge), and state updates use <= only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q     <= '0;
      cur_lvl_q <= '0;
      cnt_q     <= '0;
      div_q     <= RST_DIV;
      sq_q      <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      lvl_q     <= lvl_i;
      cur_lvl_q <= cur_lvl_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      sq_q      <= sq_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
    end
  end

  assign lvl_q_o   = lvl_q;
  assign clk_o     = sq_q;
  assign tick_o    = tick_q;
  assign ack_o     = ack_q;
  assign cur_lvl_o = cur_lvl_q;

endmodule

// File: rtl/mod_tick_gen.sv
// Multi-channel level-selectable tick generator: slices ports per channel and
// looks up each channel's pending divisor from the shared table.
module mod_tick_gen
  import mod_tick_gen_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = MTG_CNT_W,
  parameter int LVL_W  = MTG_LVL_W,
  parameter logic [(2**LVL_W)*CNT_W-1:0] DIV_TABLE = MTG_DEF_TABLE,
  parameter bit SYNC_SW = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_CH*LVL_W-1:0] In,
  input  logic [NUM_CH-1:0]       Restart,
  input  logic [NUM_CH-1:0]       Pause,
  output logic [NUM_CH-1:0]       ClkOut,
  output logic [NUM_CH-1:0]       Tick,
  output logic [NUM_CH-1:0]       LvlAck,
  output logic [NUM_CH*LVL_W-1:0] CurLvl
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LVL_W-1:0] lvl_q;
    logic [CNT_W-1:0] pend_div;

    assign pend_div = DIV_TABLE[lvl_q*CNT_W +: CNT_W];

    mod_tick_ch #(
      .CNT_W   (CNT_W),
      .LVL_W   (LVL_W),
      .SYNC_SW (SYNC_SW),
      .RST_DIV (DIV_TABLE[CNT_W-1:0])
    ) u_ch (
      .clk        (Clk),
      .rst_n      (Rst),
      .lvl_i      (In[c*LVL_W +: LVL_W]),
      .restart_i  (Restart[c]),
      .pause_i    (Pause[c]),
      .pend_div_i (pend_div),
      .lvl_q_o    (lvl_q),
      .clk_o      (ClkOut[c]),
      .tick_o     (Tick[c]),
      .ack_o      (LvlAck[c]),
      .cur_lvl_o  (CurLvl[c*LVL_W +: LVL_W])
    );
  end

endmodule

// File: tb/tb_mod_tick_gen.sv
// Bench for mod_tick_gen: a boundary-switching instance and a legacy-restart
// instance, directed vectors, corner sequences and a random run against a model.
module tb_mod_tick_gen;
  import mod_tick_gen_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_s = '0, in_l = '0;
  logic [1:0] rs_s = '0, rs_l = '0, pa_s = '0, pa_l = '0;
  logic [1:0] co_s, tk_s, ak_s, co_l, tk_l, ak_l;
  logic [7:0] cl_s, cl_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_tick_gen #(
    .NUM_CH(2), .CNT_W(MTG_CNT_W), .LVL_W(4), .DIV_TABLE(MTG_TB_TABLE), .SYNC_SW(1'b1)
  ) u_sync (
    .Clk(clk), .Rst(rst_n), .In(in_s), .Restart(rs_s), .Pause(pa_s),
    .ClkOut(co_s), .Tick(tk_s), .LvlAck(ak_s), .CurLvl(cl_s)
  );

  mod_tick_gen #(
    .NUM_CH(2), .CNT_W(MTG_CNT_W), .LVL_W(4), .DIV_TABLE(MTG_TB_TABLE), .SYNC_SW(1'b0)
  ) u_leg (
    .Clk(clk), .Rst(rst_n), .In(in_l), .Restart(rs_l), .Pause(pa_l),
    .ClkOut(co_l), .Tick(tk_l), .LvlAck(ak_l), .CurLvl(cl_l)
  );

  // Reference model: [instance][channel]; divisor is implied by the level in use.
  int m_lvlq [2][2];
  int m_cur  [2][2];
  int m_el   [2][2];
  bit m_clk  [2][2];
  bit m_tick [2][2];
  bit m_ack  [2][2];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++) begin
        m_lvlq[k][c] = 0; m_cur[k][c] = 0; m_el[k][c] = 0;
        m_clk[k][c] = 0; m_tick[k][c] = 0; m_ack[k][c] = 0;
      end
  end

  function automatic int half_len(int lvl);
    case (lvl)
      0:       return 4;
      1:       return 2;
      2:       return 1;
      default: return 6;
    endcase
  endfunction

  task automatic model_edge(int k, logic [7:0] in_v, logic [1:0] rs, logic [1:0] pa, bit sync);
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        m_lvlq[k][c] = 0; m_cur[k][c] = 0; m_el[k][c] = 0;
        m_clk[k][c] = 0; m_tick[k][c] = 0; m_ack[k][c] = 0;
      end else begin
        int old;
        bit diff;
        old = m_lvlq[k][c];
        diff = (old != m_cur[k][c]);
        m_lvlq[k][c] = int'(in_v[c*4 +: 4]);
        if (rs[c] || (!sync && diff)) begin
          m_ack[k][c] = diff; m_cur[k][c] = old; m_el[k][c] = 0;
          m_clk[k][c] = 0; m_tick[k][c] = 0;
        end else if (pa[c]) begin
          m_tick[k][c] = 0; m_ack[k][c] = 0;
        end else if (m_el[k][c] + 1 == half_len(m_cur[k][c])) begin
          m_el[k][c] = 0; m_clk[k][c] = ~m_clk[k][c]; m_tick[k][c] = 1; m_ack[k][c] = 0;
          if (sync && diff) begin
            m_cur[k][c] = old; m_ack[k][c] = 1;
          end
        end else begin
          m_el[k][c]++; m_tick[k][c] = 0; m_ack[k][c] = 0;
        end
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 2; k++) begin
      logic [1:0] e_clk, e_tick, e_ack;
      logic [7:0] e_cur;
      for (int c = 0; c < 2; c++) begin
        e_clk[c] = m_clk[k][c];
        e_tick[c] = m_tick[k][c];
        e_ack[c] = m_ack[k][c];
        e_cur[c*4 +: 4] = 4'(m_cur[k][c]);
      end
      check($sformatf("model[%0d] ClkOut", k), (k == 0) ? co_s : co_l, e_clk);
      check($sformatf("model[%0d] Tick", k),   (k == 0) ? tk_s : tk_l, e_tick);
      check($sformatf("model[%0d] LvlAck", k), (k == 0) ? ak_s : ak_l, e_ack);
      check($sformatf("model[%0d] CurLvl", k), (k == 0) ? cl_s : cl_l, e_cur);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, in_s, rs_s, pa_s, 1'b1);
    model_edge(1, in_l, rs_l, pa_l, 1'b0);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic [3:0] in0;
    logic [3:0] in1;
    int         cyc;
    logic [1:0] e_clk;
    logic [1:0] e_tick;
    logic [1:0] e_ack;
    logic [3:0] e_cur0;
    logic [3:0] e_cur1;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n;
    // Expected values on the sync instance after each vector's cycles; bit1=ch1, bit0=ch0.
    vecs[0]  = '{4'd0, 4'd0, 3, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0};
    vecs[1]  = '{4'd0, 4'd0, 1, 2'b11, 2'b11, 2'b00, 4'd0, 4'd0};
    vecs[2]  = '{4'd0, 4'd0, 1, 2'b11, 2'b00, 2'b00, 4'd0, 4'd0};
    vecs[3]  = '{4'd1, 4'd0, 1, 2'b11, 2'b00, 2'b00, 4'd0, 4'd0};
    vecs[4]  = '{4'd1, 4'd0, 1, 2'b11, 2'b00, 2'b00, 4'd0, 4'd0};
    vecs[5]  = '{4'd1, 4'd0, 1, 2'b00, 2'b11, 2'b01, 4'd1, 4'd0};
    vecs[6]  = '{4'd1, 4'd0, 1, 2'b00, 2'b00, 2'b00, 4'd1, 4'd0};
    vecs[7]  = '{4'd1, 4'd0, 1, 2'b01, 2'b01, 2'b00, 4'd1, 4'd0};
    vecs[8]  = '{4'd2, 4'd0, 1, 2'b01, 2'b00, 2'b00, 4'd1, 4'd0};
    vecs[9]  = '{4'd2, 4'd0, 1, 2'b10, 2'b11, 2'b01, 4'd2, 4'd0};
    vecs[10] = '{4'd2, 4'd0, 1, 2'b11, 2'b01, 2'b00, 4'd2, 4'd0};
    vecs[11] = '{4'd2, 4'd0, 1, 2'b10, 2'b01, 2'b00, 4'd2, 4'd0};

    // Reset state
    rst_n = 1'b0;
    step(); step();
    check("reset ClkOut", co_s, 2'b00);
    check("reset Tick",   tk_s, 2'b00);
    check("reset LvlAck", ak_s, 2'b00);
    check("reset CurLvl", cl_s, 8'h00);
    rst_n = 1'b1;

    // Steady division, mid-half-period level change, then Div==0
    for (int i = 0; i < 12; i++) begin
      in_s = {vecs[i].in1, vecs[i].in0};
      repeat (vecs[i].cyc) step();
      check($sformatf("vec%0d ClkOut", i), co_s, vecs[i].e_clk);
      check($sformatf("vec%0d Tick", i),   tk_s, vecs[i].e_tick);
      check($sformatf("vec%0d LvlAck", i), ak_s, vecs[i].e_ack);
      check($sformatf("vec%0d CurLvl0", i), cl_s[3:0], vecs[i].e_cur0);
      check($sformatf("vec%0d CurLvl1", i), cl_s[7:4], vecs[i].e_cur1);
    end

    // Back to level 0, then pause at Cnt=2 with a level change pending
    in_s[3:0] = 4'd0;
    step(); step();
    check("lvl0 switch ClkOut0", co_s[0], 1'b0);
    check("lvl0 switch LvlAck0", ak_s[0], 1'b1);
    check("lvl0 switch CurLvl0", cl_s[3:0], 4'd0);
    step(); step();
    pa_s[0] = 1'b1;
    in_s[3:0] = 4'd1;
    repeat (10) step();
    check("pause ClkOut0 frozen", co_s[0], 1'b0);
    check("pause Tick0 low", tk_s[0], 1'b0);
    check("pause CurLvl0 held", cl_s[3:0], 4'd0);
    pa_s[0] = 1'b0;
    step();
    check("resume+1 Tick0", tk_s[0], 1'b0);
    step();
    check("resume+2 ClkOut0", co_s[0], 1'b1);
    check("resume+2 Tick0", tk_s[0], 1'b1);
    check("resume+2 LvlAck0", ak_s[0], 1'b1);
    check("resume+2 CurLvl0", cl_s[3:0], 4'd1);

    // Restart ch1 at Cnt=2 with its level already changed 0->1
    n = 0;
    while (tk_s[1] !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    check("ch1 tick seen before restart", tk_s[1], 1'b1);
    step();
    in_s[7:4] = 4'd1;
    step();
    rs_s[1] = 1'b1;
    step();
    rs_s[1] = 1'b0;
    check("restart ClkOut1", co_s[1], 1'b0);
    check("restart Tick1", tk_s[1], 1'b0);
    check("restart LvlAck1", ak_s[1], 1'b1);
    check("restart CurLvl1", cl_s[7:4], 4'd1);
    step();
    check("restart+1 Tick1", tk_s[1], 1'b0);
    step();
    check("restart+2 Tick1", tk_s[1], 1'b1);
    check("restart+2 ClkOut1", co_s[1], 1'b1);

    // Legacy instance: level change restarts the channel two edges after In moves
    in_l[3:0] = 4'd1;
    step();
    check("legacy +1 LvlAck0", ak_l[0], 1'b0);
    check("legacy +1 CurLvl0", cl_l[3:0], 4'd0);
    step();
    check("legacy +2 ClkOut0", co_l[0], 1'b0);
    check("legacy +2 Tick0", tk_l[0], 1'b0);
    check("legacy +2 LvlAck0", ak_l[0], 1'b1);
    check("legacy +2 CurLvl0", cl_l[3:0], 4'd1);

    // Reset mid-period clears everything on the next edge
    step(); step(); step();
    rst_n = 1'b0;
    step();
    check("midrst sync ClkOut", co_s, 2'b00);
    check("midrst sync Tick", tk_s, 2'b00);
    check("midrst sync LvlAck", ak_s, 2'b00);
    check("midrst sync CurLvl", cl_s, 8'h00);
    check("midrst leg ClkOut", co_l, 2'b00);
    check("midrst leg Tick", tk_l, 2'b00);
    check("midrst leg CurLvl", cl_l, 8'h00);
    rst_n = 1'b1;

    // Random traffic on both instances against the model
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(15) == 0) in_s[c*4 +: 4] = 4'($urandom_range(15));
        if ($urandom_range(15) == 0) in_l[c*4 +: 4] = 4'($urandom_range(15));
        rs_s[c] = ($urandom_range(31) == 0);
        rs_l[c] = ($urandom_range(31) == 0);
        if ($urandom_range(15) == 0) pa_s[c] = ~pa_s[c];
        if ($urandom_range(15) == 0) pa_l[c] = ~pa_l[c];
      end
      rst_n = ($urandom_range(499) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
